// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared control-bundle layout and opcode constants
package pipe_pkg;

    localparam int CTL_W        = 10;
    localparam int CTL_REGDEST  = 0;
    localparam int CTL_BRANCH   = 1;
    localparam int CTL_MEMREAD  = 2;
    localparam int CTL_MEMTOREG = 3;
    localparam int CTL_ALUOP1   = 4;
    localparam int CTL_ALUOP2   = 5;
    localparam int CTL_MEMWRITE = 6;
    localparam int CTL_ALUSRC   = 7;
    localparam int CTL_REGWRITE = 8;
    localparam int CTL_JUMP     = 9;

    localparam logic [CTL_W-1:0] CTL_BUBBLE = '0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

endpackage

// File: rtl/pipe_ctrl_tracker_hazard.sv
// rtl/pipe_ctrl_tracker_hazard.sv - load-use detection and fetch-control priority
module hazard_unit #(
    parameter int REG_W = 5
) (
    input  logic             mem_stall,
    input  logic             ex_branch_taken,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_jump,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             bubble
);

    logic load_use;

    assign load_use = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // A taken branch wins over load-use: the stalled ID instruction is wrong-path anyway.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        bubble     = 1'b0;
        if (mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            bubble     = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
        end else begin
            ifid_flush = id_jump;
        end
    end

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// rtl/pipe_ctrl_tracker.sv - ID/EX, EX/MEM, MEM/WB control pipeline with hazard handling
module pipe_ctrl_tracker
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       id_ctrl,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_stall,
    output logic [9:0]       ex_ctrl,
    output logic [REG_W-1:0] ex_rt,
    output logic [REG_W-1:0] ex_wreg,
    output logic [9:0]       mem_ctrl,
    output logic [REG_W-1:0] mem_wreg,
    output logic [9:0]       wb_ctrl,
    output logic [REG_W-1:0] wb_wreg,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic hz_pc_write;
    logic hz_ifid_write;
    logic hz_ifid_flush;
    logic bubble;

    hazard_unit #(.REG_W(REG_W)) u_hazard (
        .mem_stall       (mem_stall),
        .ex_branch_taken (ex_branch_taken),
        .ex_memread      (ex_ctrl[CTL_MEMREAD]),
        .ex_rt           (ex_rt),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_jump         (id_ctrl[CTL_JUMP]),
        .pc_write        (hz_pc_write),
        .ifid_write      (hz_ifid_write),
        .ifid_flush      (hz_ifid_flush),
        .bubble          (bubble)
    );

    // Fetch controls idle at "run, no flush" while the pipeline is held in reset.
    assign pc_write   = !rst_n || hz_pc_write;
    assign ifid_write = !rst_n || hz_ifid_write;
    assign ifid_flush = rst_n && hz_ifid_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl    <= CTL_BUBBLE;
            ex_rt      <= '0;
            ex_wreg    <= '0;
            mem_ctrl   <= CTL_BUBBLE;
            mem_wreg   <= '0;
            wb_ctrl    <= CTL_BUBBLE;
            wb_wreg    <= '0;
            bubble_cnt <= '0;
        end else if (!mem_stall) begin
            wb_ctrl  <= mem_ctrl;
            wb_wreg  <= mem_wreg;
            mem_ctrl <= ex_ctrl;
            mem_wreg <= ex_wreg;
            if (bubble) begin
                ex_ctrl <= CTL_BUBBLE;
                ex_rt   <= '0;
                ex_wreg <= '0;
                if (bubble_cnt != '1) begin
                    bubble_cnt <= bubble_cnt + 1'b1;
                end
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rt   <= id_rt;
                ex_wreg <= id_ctrl[CTL_REGDEST] ? id_rd : id_rt;
            end
        end
    end

endmodule
